// File: rtl/string_diff_if.sv
// Request/result bundle between the sequencer and string_diff.
// The sequencer holds the master side; string_diff holds the slave side.
interface string_diff_if #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned CNT_WIDTH  = 3
);
   logic                  vld_i;
   logic [ADDR_WIDTH-1:0] a_i;
   logic [ADDR_WIDTH-1:0] b_i;
   logic                  rdy_o;
   logic                  done_o;
   logic [CNT_WIDTH-1:0]  mismatches_o;
   logic                  almost_match_o;
   logic                  first_vld_o;
   logic [ADDR_WIDTH-1:0] first_pos_o;
   logic [ADDR_WIDTH-1:0] len_o;
   logic                  len_mismatch_o;

   modport master (
      output vld_i, a_i, b_i,
      input  rdy_o, done_o, mismatches_o, almost_match_o,
             first_vld_o, first_pos_o, len_o, len_mismatch_o
   );

   modport slave (
      input  vld_i, a_i, b_i,
      output rdy_o, done_o, mismatches_o, almost_match_o,
             first_vld_o, first_pos_o, len_o, len_mismatch_o
   );
endinterface

// File: rtl/string_diff.sv
// Walks two null-terminated strings through one shared read port and counts
// differing positions with a saturating counter. Two cycles per position:
// RD_B fetches the B character while CMP compares it and prefetches the next
// A character, so the A read of the following position overlaps the compare.
module string_diff #(
   parameter int unsigned ADDR_WIDTH = 14,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 3,
   parameter bit          EARLY_EXIT = 1'b0,
   parameter int unsigned LIMIT      = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   string_diff_if.slave          bus,
   output logic [ADDR_WIDTH-1:0] mem_raddr_o,
   output logic                  mem_ren_o,
   input  logic [DATA_WIDTH-1:0] mem_rdat_i
);

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_B,
      CMP,
      DONE
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0]  LIMIT_C  = CNT_WIDTH'(LIMIT);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] aptr_q, aptr_d;
   logic [ADDR_WIDTH-1:0] bptr_q, bptr_d;
   logic [DATA_WIDTH-1:0] tmp_q, tmp_d;
   logic [ADDR_WIDTH-1:0] pos_q, pos_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  first_vld_q, first_vld_d;
   logic [ADDR_WIDTH-1:0] first_pos_q, first_pos_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   logic                  len_mm_q, len_mm_d;

   logic                  a_end;
   logic                  b_end;
   logic                  mismatch;
   logic [CNT_WIDTH-1:0]  cnt_upd;
   logic                  term;

   // Next-state, read-port drive and result updates.
   always_comb begin
      state_d     = state_q;
      aptr_d      = aptr_q;
      bptr_d      = bptr_q;
      tmp_d       = tmp_q;
      pos_d       = pos_q;
      cnt_d       = cnt_q;
      first_vld_d = first_vld_q;
      first_pos_d = first_pos_q;
      len_d       = len_q;
      len_mm_d    = len_mm_q;
      mem_raddr_o = '0;
      mem_ren_o   = 1'b0;

      // In CMP, tmp_q holds the A character and mem_rdat_i the B character.
      a_end    = (tmp_q == '0);
      b_end    = (mem_rdat_i == '0);
      mismatch = (tmp_q != mem_rdat_i);
      cnt_upd  = (mismatch && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;
      term     = a_end || b_end || (EARLY_EXIT && (cnt_upd >= LIMIT_C));

      case (state_q)
         IDLE: begin
            if (bus.vld_i) begin
               state_d     = RD_A;
               aptr_d      = bus.a_i;
               bptr_d      = bus.b_i;
               pos_d       = '0;
               cnt_d       = '0;
               first_vld_d = 1'b0;
               first_pos_d = '0;
               len_d       = '0;
               len_mm_d    = 1'b0;
            end
         end
         RD_A: begin
            mem_raddr_o = aptr_q;
            mem_ren_o   = 1'b1;
            aptr_d      = aptr_q + ADDR_ONE;
            state_d     = RD_B;
         end
         RD_B: begin
            mem_raddr_o = bptr_q;
            mem_ren_o   = 1'b1;
            bptr_d      = bptr_q + ADDR_ONE;
            tmp_d       = mem_rdat_i;
            state_d     = CMP;
         end
         CMP: begin
            // Prefetch the next A character; discarded if the walk ends here.
            mem_raddr_o = aptr_q;
            mem_ren_o   = 1'b1;
            aptr_d      = aptr_q + ADDR_ONE;
            pos_d       = pos_q + ADDR_ONE;
            cnt_d       = cnt_upd;
            if (mismatch && !first_vld_q) begin
               first_vld_d = 1'b1;
               first_pos_d = pos_q;
            end
            if (term) begin
               len_d    = pos_q;
               len_mm_d = a_end ^ b_end;
               state_d  = DONE;
            end else begin
               state_d  = RD_B;
            end
         end
         DONE: begin
            if (!bus.vld_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset discards any partial walk.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         aptr_q      <= '0;
         bptr_q      <= '0;
         tmp_q       <= '0;
         pos_q       <= '0;
         cnt_q       <= '0;
         first_vld_q <= 1'b0;
         first_pos_q <= '0;
         len_q       <= '0;
         len_mm_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         aptr_q      <= aptr_d;
         bptr_q      <= bptr_d;
         tmp_q       <= tmp_d;
         pos_q       <= pos_d;
         cnt_q       <= cnt_d;
         first_vld_q <= first_vld_d;
         first_pos_q <= first_pos_d;
         len_q       <= len_d;
         len_mm_q    <= len_mm_d;
      end
   end

   assign bus.rdy_o          = (state_q == IDLE);
   assign bus.done_o         = (state_q == DONE);
   assign bus.mismatches_o   = cnt_q;
   assign bus.almost_match_o = (cnt_q == CNT_ONE);
   assign bus.first_vld_o    = first_vld_q;
   assign bus.first_pos_o    = first_pos_q;
   assign bus.len_o          = len_q;
   assign bus.len_mismatch_o = len_mm_q;

endmodule

// File: tb/tb_string_diff.sv
// Directed bench for string_diff: a default instance and an early-exit
// instance (LIMIT=2), each with its own read port on one shared character
// memory that has one cycle of read latency.
module tb_string_diff;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [13:0] raddr, raddr_ee;
   logic        ren, ren_ee;
   logic [7:0]  rdat = '0;
   logic [7:0]  rdat_ee = '0;
   logic [7:0]  mem [0:255];

   int vectors = 0;
   int miscompares = 0;

   string_diff_if #(.ADDR_WIDTH(14), .CNT_WIDTH(3)) bus ();
   string_diff_if #(.ADDR_WIDTH(14), .CNT_WIDTH(3)) bus_ee ();

   string_diff #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .CNT_WIDTH(3)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus),
      .mem_raddr_o(raddr), .mem_ren_o(ren), .mem_rdat_i(rdat)
   );

   string_diff #(.ADDR_WIDTH(14), .DATA_WIDTH(8), .CNT_WIDTH(3),
                 .EARLY_EXIT(1'b1), .LIMIT(2)) dut_ee (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus_ee),
      .mem_raddr_o(raddr_ee), .mem_ren_o(ren_ee), .mem_rdat_i(rdat_ee)
   );

   always #5 clk = ~clk;

   // Registered read ports of the shared character memory.
   always @(posedge clk) begin
      rdat    <= mem[raddr[7:0]];
      rdat_ee <= mem[raddr_ee[7:0]];
   end

   task automatic put(input int addr, input string s);
      for (int i = 0; i < s.len(); i++) mem[addr + i] = s[i];
      mem[addr + s.len()] = 8'h00;
   endtask

   // Raise vld at a negedge; returns right at the accept edge.
   task automatic accept(input bit ee, input int a, input int b);
      @(negedge clk);
      if (ee) begin
         bus_ee.vld_i = 1'b1; bus_ee.a_i = 14'(a); bus_ee.b_i = 14'(b);
      end else begin
         bus.vld_i = 1'b1; bus.a_i = 14'(a); bus.b_i = 14'(b);
      end
      @(posedge clk);
   endtask

   // Edges from accept until done_o is seen; -1 if the budget runs out.
   task automatic wait_done(input bit ee, output int lat);
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         if ((ee ? bus_ee.done_o : bus.done_o) === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic release_vld(input bit ee);
      @(negedge clk);
      if (ee) bus_ee.vld_i = 1'b0;
      else    bus.vld_i = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      vectors++; if (bus.rdy_o !== 1'b1) begin miscompares++; $display("FAIL reset_rdy: got %b expected 1", bus.rdy_o); end
      vectors++; if (bus.done_o !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
      vectors++; if (ren !== 1'b0 || raddr !== 14'd0) begin miscompares++; $display("FAIL reset_mem: got ren=%b addr=%0d expected 0/0", ren, raddr); end
      vectors++; if (bus.mismatches_o !== 3'd0 || bus.first_vld_o !== 1'b0 || bus.len_o !== 14'd0) begin
         miscompares++; $display("FAIL reset_results: got cnt=%0d fv=%b len=%0d expected 0/0/0", bus.mismatches_o, bus.first_vld_o, bus.len_o); end
      vectors++; if (bus_ee.rdy_o !== 1'b1) begin miscompares++; $display("FAIL reset_rdy_ee: got %b expected 1", bus_ee.rdy_o); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_basic;
      int lat;
      accept(0, 40, 56);
      #1;
      vectors++; if (ren !== 1'b1 || raddr !== 14'd40) begin miscompares++; $display("FAIL basic_rda: got ren=%b addr=%0d expected 1/40", ren, raddr); end
      @(posedge clk); #1;
      vectors++; if (raddr !== 14'd56) begin miscompares++; $display("FAIL basic_rdb: got addr=%0d expected 56", raddr); end
      wait_done(0, lat);
      lat = lat + 1;  // two edges already consumed above
      vectors++; if (lat !== 11) begin miscompares++; $display("FAIL basic_lat: got %0d expected 11", lat); end
      vectors++; if (bus.mismatches_o !== 3'd1) begin miscompares++; $display("FAIL basic_cnt: got %0d expected 1", bus.mismatches_o); end
      vectors++; if (bus.almost_match_o !== 1'b1) begin miscompares++; $display("FAIL basic_almost: got %b expected 1", bus.almost_match_o); end
      vectors++; if (bus.first_vld_o !== 1'b1 || bus.first_pos_o !== 14'd2) begin miscompares++; $display("FAIL basic_first: got %b/%0d expected 1/2", bus.first_vld_o, bus.first_pos_o); end
      vectors++; if (bus.len_o !== 14'd4 || bus.len_mismatch_o !== 1'b0) begin miscompares++; $display("FAIL basic_len: got %0d/%b expected 4/0", bus.len_o, bus.len_mismatch_o); end
      vectors++; if (ren !== 1'b0 || raddr !== 14'd0) begin miscompares++; $display("FAIL basic_done_mem: got ren=%b addr=%0d expected 0/0", ren, raddr); end
      release_vld(0);
      @(posedge clk);
   endtask

   task automatic test_len_mismatch;
      int lat;
      accept(0, 72, 88);
      wait_done(0, lat);
      vectors++; if (lat !== 9) begin miscompares++; $display("FAIL lenmm_lat: got %0d expected 9", lat); end
      vectors++; if (bus.mismatches_o !== 3'd1 || bus.first_pos_o !== 14'd3) begin miscompares++; $display("FAIL lenmm_cnt: got %0d/%0d expected 1/3", bus.mismatches_o, bus.first_pos_o); end
      vectors++; if (bus.len_o !== 14'd3 || bus.len_mismatch_o !== 1'b1) begin miscompares++; $display("FAIL lenmm_len: got %0d/%b expected 3/1", bus.len_o, bus.len_mismatch_o); end
      release_vld(0);
      @(posedge clk);
   endtask

   task automatic test_saturate;
      int lat;
      accept(0, 104, 120);
      wait_done(0, lat);
      vectors++; if (lat !== 21) begin miscompares++; $display("FAIL sat_lat: got %0d expected 21", lat); end
      vectors++; if (bus.mismatches_o !== 3'd7 || bus.almost_match_o !== 1'b0) begin miscompares++; $display("FAIL sat_cnt: got %0d/%b expected 7/0", bus.mismatches_o, bus.almost_match_o); end
      vectors++; if (bus.first_vld_o !== 1'b1 || bus.first_pos_o !== 14'd0) begin miscompares++; $display("FAIL sat_first: got %b/%0d expected 1/0", bus.first_vld_o, bus.first_pos_o); end
      vectors++; if (bus.len_o !== 14'd9 || bus.len_mismatch_o !== 1'b0) begin miscompares++; $display("FAIL sat_len: got %0d/%b expected 9/0", bus.len_o, bus.len_mismatch_o); end
      release_vld(0);
      @(posedge clk);
   endtask

   task automatic test_early_exit;
      int lat;
      accept(1, 136, 152);
      wait_done(1, lat);
      vectors++; if (lat !== 9) begin miscompares++; $display("FAIL ee_lat: got %0d expected 9", lat); end
      vectors++; if (bus_ee.mismatches_o !== 3'd2 || bus_ee.first_pos_o !== 14'd1) begin miscompares++; $display("FAIL ee_cnt: got %0d/%0d expected 2/1", bus_ee.mismatches_o, bus_ee.first_pos_o); end
      vectors++; if (bus_ee.len_o !== 14'd3 || bus_ee.len_mismatch_o !== 1'b0) begin miscompares++; $display("FAIL ee_len: got %0d/%b expected 3/0", bus_ee.len_o, bus_ee.len_mismatch_o); end
      release_vld(1);
      @(posedge clk);
      // Same strings without early exit walk to the terminators.
      accept(0, 136, 152);
      wait_done(0, lat);
      vectors++; if (lat !== 13) begin miscompares++; $display("FAIL noee_lat: got %0d expected 13", lat); end
      vectors++; if (bus.mismatches_o !== 3'd2 || bus.len_o !== 14'd5) begin miscompares++; $display("FAIL noee_res: got %0d/%0d expected 2/5", bus.mismatches_o, bus.len_o); end
      release_vld(0);
      @(posedge clk);
   endtask

   task automatic test_back_to_back;
      int lat;
      accept(0, 40, 56);
      wait_done(0, lat);
      vectors++; if (lat !== 11) begin miscompares++; $display("FAIL b2b_first_lat: got %0d expected 11", lat); end
      release_vld(0);
      @(posedge clk); #1;
      vectors++; if (bus.rdy_o !== 1'b1) begin miscompares++; $display("FAIL b2b_rdy1: got %b expected 1", bus.rdy_o); end
      accept(0, 168, 176);
      #1;
      vectors++; if (bus.mismatches_o !== 3'd0 || bus.first_vld_o !== 1'b0 || bus.first_pos_o !== 14'd0 || bus.len_o !== 14'd0) begin
         miscompares++; $display("FAIL b2b_clear: got cnt=%0d fv=%b fp=%0d len=%0d expected 0/0/0/0", bus.mismatches_o, bus.first_vld_o, bus.first_pos_o, bus.len_o); end
      wait_done(0, lat);
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL b2b_empty_lat: got %0d expected 3", lat); end
      vectors++; if (bus.mismatches_o !== 3'd0 || bus.len_o !== 14'd0 || bus.len_mismatch_o !== 1'b0) begin miscompares++; $display("FAIL b2b_empty_res: got %0d/%0d/%b expected 0/0/0", bus.mismatches_o, bus.len_o, bus.len_mismatch_o); end
      release_vld(0);
      @(posedge clk); #1;
      vectors++; if (bus.rdy_o !== 1'b1) begin miscompares++; $display("FAIL b2b_rdy2: got %b expected 1", bus.rdy_o); end
      accept(0, 184, 192);
      wait_done(0, lat);
      vectors++; if (lat !== 7) begin miscompares++; $display("FAIL b2b_ab_lat: got %0d expected 7", lat); end
      vectors++; if (bus.mismatches_o !== 3'd0 || bus.first_vld_o !== 1'b0 || bus.len_o !== 14'd2) begin miscompares++; $display("FAIL b2b_ab_res: got %0d/%b/%0d expected 0/0/2", bus.mismatches_o, bus.first_vld_o, bus.len_o); end
      release_vld(0);
      @(posedge clk);
   endtask

   task automatic test_reset_midwalk;
      int lat;
      accept(0, 200, 216);
      repeat (6) @(posedge clk);  // now in CMP of position 2
      #1;
      vectors++; if (bus.first_vld_o !== 1'b1 || ren !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got fv=%b ren=%b expected 1/1", bus.first_vld_o, ren); end
      #1;
      rst_n = 1'b0;
      bus.vld_i = 1'b0;
      #1;
      vectors++; if (bus.rdy_o !== 1'b1 || bus.done_o !== 1'b0) begin miscompares++; $display("FAIL mid_state: got rdy=%b done=%b expected 1/0", bus.rdy_o, bus.done_o); end
      vectors++; if (ren !== 1'b0 || raddr !== 14'd0) begin miscompares++; $display("FAIL mid_mem: got ren=%b addr=%0d expected 0/0", ren, raddr); end
      vectors++; if (bus.mismatches_o !== 3'd0 || bus.first_vld_o !== 1'b0 || bus.first_pos_o !== 14'd0 || bus.len_o !== 14'd0 || bus.len_mismatch_o !== 1'b0) begin
         miscompares++; $display("FAIL mid_results: got cnt=%0d fv=%b fp=%0d len=%0d lm=%b expected all 0", bus.mismatches_o, bus.first_vld_o, bus.first_pos_o, bus.len_o, bus.len_mismatch_o); end
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      accept(0, 200, 216);
      wait_done(0, lat);
      vectors++; if (lat !== 15) begin miscompares++; $display("FAIL restart_lat: got %0d expected 15", lat); end
      vectors++; if (bus.mismatches_o !== 3'd1 || bus.first_pos_o !== 14'd1) begin miscompares++; $display("FAIL restart_cnt: got %0d/%0d expected 1/1", bus.mismatches_o, bus.first_pos_o); end
      vectors++; if (bus.len_o !== 14'd6 || bus.len_mismatch_o !== 1'b0) begin miscompares++; $display("FAIL restart_len: got %0d/%b expected 6/0", bus.len_o, bus.len_mismatch_o); end
      release_vld(0);
      @(posedge clk);
   endtask

   initial begin
      bus.vld_i = 1'b0;    bus.a_i = '0;    bus.b_i = '0;
      bus_ee.vld_i = 1'b0; bus_ee.a_i = '0; bus_ee.b_i = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      put(40, "abcd");       put(56, "abxd");
      put(72, "abc");        put(88, "abcde");
      put(104, "aaaaaaaaa"); put(120, "bbbbbbbbb");
      put(136, "axbyc");     put(152, "a1b2c");
      put(168, "");          put(176, "");
      put(184, "ab");        put(192, "ab");
      put(200, "abcdef");    put(216, "aXcdef");

      test_reset;
      test_basic;
      test_len_mismatch;
      test_saturate;
      test_early_exit;
      test_back_to_back;
      test_reset_midwalk;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
